// File: rtl/arb_pkg.sv
// Shared types and constants for the I/D-cache memory port arbiter.
package arb_pkg;

  localparam int unsigned ADDR_W_DEF = 28;
  localparam int unsigned DATA_W_DEF = 128;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE  = 2'd0;
  localparam arb_state_t GNT_I = 2'd1;
  localparam arb_state_t GNT_D = 2'd2;
  localparam arb_state_t DONE  = 2'd3;

  typedef logic req_id_t;

  localparam req_id_t REQ_I = 1'b0;
  localparam req_id_t REQ_D = 1'b1;

  function automatic arb_state_t gnt_state(input req_id_t id);
    return (id == REQ_D) ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between the I and D requesters.
// ARB_ROUND_ROBIN_EN swaps fixed D-over-I priority for alternation on contention.
module arb_pick
  import arb_pkg::*;
(
  input  logic    i_pend_i,
  input  logic    d_pend_i,
  input  req_id_t last_grant_i,
  output req_id_t winner_o,
  output logic    valid_o
);

  assign valid_o = i_pend_i | d_pend_i;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    winner_o = d_pend_i ? REQ_D : REQ_I;
    // On contention the side not served last time goes first
    if (i_pend_i && d_pend_i) begin
      winner_o = (last_grant_i == REQ_D) ? REQ_I : REQ_D;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  always_comb begin
    winner_o = d_pend_i ? REQ_D : REQ_I;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the external block-memory port between the I-cache and D-cache miss engines.
// Optional ARB_ROUND_ROBIN_EN enables alternating priority via a last_grant register.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_t        state_q, state_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  req_id_t winner;
  logic    win_valid;
  req_id_t last_grant;

`ifdef ARB_ROUND_ROBIN_EN
  req_id_t last_grant_q, last_grant_d;
  assign last_grant = last_grant_q;
`else
  assign last_grant = REQ_I;
`endif

  arb_pick u_pick (
    .i_pend_i     (i_read),
    .d_pend_i     (d_read | d_write),
    .last_grant_i (last_grant),
    .winner_o     (winner),
    .valid_o      (win_valid)
  );

  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = gnt_state(winner);
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = winner;
`endif
          if (winner == REQ_D) begin
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            // Read+write together is a protocol error; the write wins
            mem_write_d = d_write;
            mem_read_d  = d_read & ~d_write;
          end else begin
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
            mem_write_d = 1'b0;
            mem_read_d  = 1'b1;
          end
        end
      end
      GNT_I, GNT_D: begin
        if (mem_ready) begin
          state_d     = DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      DONE: begin
        // Bubble cycle so a request still held from the last transfer is not re-granted
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= REQ_I;
`endif
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Completion is the only combinational path through the block
  assign i_ready = (state_q == GNT_I) & mem_ready;
  assign d_ready = (state_q == GNT_D) & mem_ready;
  assign i_rdata = i_ready ? mem_rdata : '0;
  assign d_rdata = d_ready ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (default fixed-priority build).
module tb_mem_port_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          is_d;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            lat;
    logic          exp_rd;
    logic          exp_wr;
    logic [DW-1:0] exp_wdata;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one transaction from IDLE and returns in IDLE, 1ns after the edge
  task automatic run_txn(input int idx, input vec_t v);
    if (v.is_d) begin
      d_read  = v.rd;
      d_write = v.wr;
      d_addr  = v.addr;
      d_wdata = v.wdata;
    end else begin
      i_read = 1'b1;
      i_addr = v.addr;
    end
    @(negedge clk);
    chk($sformatf("v%0d_pre_strobe", idx), {126'd0, mem_read, mem_write}, '0);
    step();
    @(negedge clk);
    chk($sformatf("v%0d_mem_read", idx), mem_read, v.exp_rd);
    chk($sformatf("v%0d_mem_write", idx), mem_write, v.exp_wr);
    chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.addr);
    chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.exp_wdata);
    for (int k = 1; k < v.lat; k++) @(posedge clk);
    step();
    mem_ready = 1'b1;
    mem_rdata = v.rdata;
    @(negedge clk);
    if (v.is_d) begin
      chk($sformatf("v%0d_d_ready", idx), d_ready, 1'b1);
      chk($sformatf("v%0d_d_rdata", idx), d_rdata, v.rdata);
      chk($sformatf("v%0d_i_ready", idx), i_ready, 1'b0);
      chk($sformatf("v%0d_i_rdata", idx), i_rdata, '0);
    end else begin
      chk($sformatf("v%0d_i_ready", idx), i_ready, 1'b1);
      chk($sformatf("v%0d_i_rdata", idx), i_rdata, v.rdata);
      chk($sformatf("v%0d_d_ready", idx), d_ready, 1'b0);
      chk($sformatf("v%0d_d_rdata", idx), d_rdata, '0);
    end
    step();
    mem_ready = 1'b0;
    i_read    = 1'b0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_done_strobes", idx), {126'd0, mem_read, mem_write}, '0);
    chk($sformatf("v%0d_done_ready", idx), {126'd0, i_ready, d_ready}, '0);
    step();
  endtask

  initial begin
    logic [DW-1:0] ones;
    logic [DW-1:0] beef;
    ones = {32{4'h1}};
    beef = {4{32'hDEADBEEF}};

    vecs[0] = '{1'b0, 1'b1, 1'b0, 28'h0000010, '0, beef, 4, 1'b1, 1'b0, '0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 28'h0000040, 128'h55, 128'hCAFE, 2, 1'b1, 1'b0, 128'h55};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 28'h0000020, ones, 128'h0, 1, 1'b0, 1'b1, ones};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 28'h0000070, 128'hA5A5, 128'h0, 1, 1'b0, 1'b1, 128'hA5A5};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 28'hFFFFFFF, '0, ~beef, 1, 1'b1, 1'b0, '0};

    rst = 1'b1;
    i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_strobes", {126'd0, mem_read, mem_write}, '0);
    chk("rst_addr", mem_addr, '0);
    chk("rst_wdata", mem_wdata, '0);
    chk("rst_ready", {126'd0, i_ready, d_ready}, '0);
    chk("rst_rdata", i_rdata | d_rdata, '0);
    step();

    for (int n = 0; n < 5; n++) run_txn(n, vecs[n]);

    // Simultaneous I and D: D first, then I after the DONE bubble
    i_read = 1'b1; i_addr = 28'h30;
    d_write = 1'b1; d_addr = 28'h20; d_wdata = ones;
    step();
    @(negedge clk);
    chk("sim_d_write", mem_write, 1'b1);
    chk("sim_d_read", mem_read, 1'b0);
    chk("sim_d_addr", mem_addr, 28'h20);
    chk("sim_d_wdata", mem_wdata, ones);
    step();
    mem_ready = 1'b1; mem_rdata = 128'hAB;
    @(negedge clk);
    chk("sim_d_ready", d_ready, 1'b1);
    chk("sim_i_ready_low", i_ready, 1'b0);
    chk("sim_i_rdata_zero", i_rdata, '0);
    step();
    mem_ready = 1'b0; d_write = 1'b0;
    @(negedge clk);
    chk("sim_done_strobes", {126'd0, mem_read, mem_write}, '0);
    step();
    @(negedge clk);
    chk("sim_idle_no_strobe", mem_read, 1'b0);
    step();
    @(negedge clk);
    chk("sim_i_read", mem_read, 1'b1);
    chk("sim_i_addr", mem_addr, 28'h30);
    step();
    mem_ready = 1'b1; mem_rdata = 128'hC0DE;
    @(negedge clk);
    chk("sim_i_ready", i_ready, 1'b1);
    chk("sim_i_rdata", i_rdata, 128'hC0DE);
    chk("sim_d_ready_low", d_ready, 1'b0);
    step();
    mem_ready = 1'b0; i_read = 1'b0;
    step();

    // Stale request held into DONE must not be re-granted
    d_read = 1'b1; d_addr = 28'h50;
    step();
    step();
    mem_ready = 1'b1; mem_rdata = 128'h1;
    step();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("stale_done_read", mem_read, 1'b0);
    step();
    d_read = 1'b0;
    @(negedge clk);
    chk("stale_idle_read", mem_read, 1'b0);
    step();
    @(negedge clk);
    chk("stale_no_regrant", mem_read, 1'b0);
    chk("stale_no_ready", d_ready, 1'b0);
    step();

    // Requester address change during GNT_D is ignored
    d_read = 1'b1; d_addr = 28'h40;
    step();
    d_addr = 28'h80;
    @(negedge clk);
    chk("hold_addr_0", mem_addr, 28'h40);
    step();
    @(negedge clk);
    chk("hold_addr_1", mem_addr, 28'h40);
    step();
    mem_ready = 1'b1; mem_rdata = 128'h77;
    @(negedge clk);
    chk("hold_d_ready", d_ready, 1'b1);
    chk("hold_d_rdata", d_rdata, 128'h77);
    step();
    mem_ready = 1'b0; d_read = 1'b0;
    step();

    // Reset mid-transaction, then a late mem_ready
    i_read = 1'b1; i_addr = 28'h60;
    step();
    @(negedge clk);
    chk("rstmid_read_up", mem_read, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; i_read = 1'b0;
    mem_ready = 1'b1; mem_rdata = 128'h99;
    @(negedge clk);
    chk("rstmid_read_down", mem_read, 1'b0);
    chk("rstmid_addr", mem_addr, '0);
    chk("rstmid_no_ready", i_ready, 1'b0);
    chk("rstmid_no_rdata", i_rdata, '0);
    step();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rstmid_idle", {126'd0, mem_read, mem_write}, '0);
    step();

    // Spurious mem_ready while IDLE
    mem_ready = 1'b1; mem_rdata = 128'h1234;
    @(negedge clk);
    chk("spur_ready", {126'd0, i_ready, d_ready}, '0);
    chk("spur_rdata", i_rdata | d_rdata, '0);
    step();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("spur_no_strobe", {126'd0, mem_read, mem_write}, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
